prog_loader: RTL and testbench

- Writer-side counterpart to the instruction fetch path: receives a program image as a byte stream from the UART receiver and writes 32-bit instruction words into the instruction ROM write port.
- Holds the CPU in reset (cpu_hold) while loading; releases the CPU once the final word is written.
- Sits between uart_rx and the instruction memory write port (port B, address indexed by PC[15:2]).

---
 rtl/prog_loader_pkg.sv | 18 +
 rtl/prog_loader_byte_assembler.sv | 45 ++++
 rtl/prog_loader.sv | 144 ++++++++++++++
 tb/tb_prog_loader.sv | 215 +++++++++++++++++++++
 4 files changed

// File: rtl/prog_loader_pkg.sv
// Shared definitions for the UART program loader: widths, stream framing and FSM state codes.
package prog_loader_pkg;

    localparam int ISA_WIDTH      = 32;
    localparam int ADDR_WIDTH     = 14;
    localparam int HDR_BYTES      = 2;
    localparam int BYTES_PER_WORD = 4;
    localparam int HDR_BITS       = HDR_BYTES * 8;

    localparam logic [2:0] ST_IDLE   = 3'd0;
    localparam logic [2:0] ST_HDR_HI = 3'd1;
    localparam logic [2:0] ST_HDR_LO = 3'd2;
    localparam logic [2:0] ST_RECV   = 3'd3;
    localparam logic [2:0] ST_WRITE  = 3'd4;
    localparam logic [2:0] ST_DONE   = 3'd5;
    localparam logic [2:0] ST_ERROR  = 3'd6;

endpackage

// File: rtl/prog_loader_byte_assembler.sv
// Packs big-endian bytes into instruction words; word/word_ready present the completed word
// combinationally in the same cycle as its final byte.
module byte_assembler #(
    parameter int ISA_WIDTH = prog_loader_pkg::ISA_WIDTH
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 clear,
    input  logic                 byte_valid,
    input  logic [7:0]           byte_in,
    output logic [ISA_WIDTH-1:0] word,
    output logic                 word_ready
);
    import prog_loader_pkg::*;

    logic [ISA_WIDTH-9:0] shift_q, shift_d;
    logic [1:0]           idx_q, idx_d;

    assign word       = {shift_q, byte_in};
    assign word_ready = byte_valid && (idx_q == 2'(BYTES_PER_WORD - 1));

    // The index wraps 3 -> 0 on the final byte, so a byte landing during WRITE becomes byte 0.
    always_comb begin
        shift_d = shift_q;
        idx_d   = idx_q;
        if (clear) begin
            shift_d = '0;
            idx_d   = '0;
        end else if (byte_valid) begin
            shift_d = word[ISA_WIDTH-9:0];
            idx_d   = idx_q + 2'd1;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            shift_q <= '0;
            idx_q   <= '0;
        end else begin
            shift_q <= shift_d;
            idx_q   <= idx_d;
        end
    end

endmodule

// File: rtl/prog_loader.sv
// Receives a length-prefixed program image over UART and writes it into instruction memory,
// holding the CPU in reset for the duration of the load.
module prog_loader #(
    parameter int ADDR_WIDTH     = prog_loader_pkg::ADDR_WIDTH,
    parameter int ISA_WIDTH      = prog_loader_pkg::ISA_WIDTH,
    parameter int TIMEOUT_CYCLES = 10000000
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  start,
    input  logic [7:0]            rx_data,
    input  logic                  rx_valid,
    output logic                  mem_we,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [ISA_WIDTH-1:0]  mem_wdata,
    output logic                  cpu_hold,
    output logic                  done,
    output logic                  error,
    output logic [ADDR_WIDTH:0]   words_loaded
);
    import prog_loader_pkg::*;

    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

    logic [2:0]            state_q, state_d;
    logic [HDR_BITS-1:0]   n_q, n_d;
    logic [ADDR_WIDTH:0]   words_loaded_q, words_loaded_d;
    logic [TW-1:0]         timeout_q, timeout_d;
    logic                  mem_we_q, mem_we_d;
    logic [ADDR_WIDTH-1:0] mem_addr_q, mem_addr_d;
    logic [ISA_WIDTH-1:0]  mem_wdata_q, mem_wdata_d;

    logic                  asm_clear, asm_valid, asm_ready;
    logic [ISA_WIDTH-1:0]  asm_word;
    logic                  counting, timeout_hit;

    byte_assembler #(.ISA_WIDTH(ISA_WIDTH)) u_asm (
        .clock      (clock),
        .reset      (reset),
        .clear      (asm_clear),
        .byte_valid (asm_valid),
        .byte_in    (rx_data),
        .word       (asm_word),
        .word_ready (asm_ready)
    );

    assign counting    = (state_q == ST_HDR_HI) || (state_q == ST_HDR_LO) || (state_q == ST_RECV);
    assign timeout_hit = counting && !rx_valid && (timeout_q == TW'(TIMEOUT_CYCLES - 1));

    always_comb begin
        state_d        = state_q;
        n_d            = n_q;
        words_loaded_d = words_loaded_q;
        timeout_d      = timeout_q;
        mem_we_d       = 1'b0;
        mem_addr_d     = mem_addr_q;
        mem_wdata_d    = mem_wdata_q;
        asm_clear      = 1'b0;
        asm_valid      = 1'b0;

        if (counting) begin
            timeout_d = rx_valid ? '0 : timeout_q + TW'(1);
        end

        case (state_q)
            ST_IDLE, ST_DONE, ST_ERROR: begin
                if (start) begin
                    state_d        = ST_HDR_HI;
                    words_loaded_d = '0;
                    timeout_d      = '0;
                    asm_clear      = 1'b1;
                end
            end
            ST_HDR_HI: begin
                if (rx_valid) begin
                    n_d[15:8] = rx_data;
                    state_d   = ST_HDR_LO;
                end else if (timeout_hit) begin
                    state_d = ST_ERROR;
                end
            end
            ST_HDR_LO: begin
                if (rx_valid) begin
                    n_d[7:0] = rx_data;
                    if (n_d == '0)
                        state_d = ST_DONE;
                    else if (32'(n_d) > (32'd1 << ADDR_WIDTH))
                        state_d = ST_ERROR;
                    else
                        state_d = ST_RECV;
                end else if (timeout_hit) begin
                    state_d = ST_ERROR;
                end
            end
            ST_RECV: begin
                asm_valid = rx_valid;
                if (asm_ready) begin
                    // Write port is registered: it presents the word during the WRITE cycle.
                    mem_we_d    = 1'b1;
                    mem_addr_d  = words_loaded_q[ADDR_WIDTH-1:0];
                    mem_wdata_d = asm_word;
                    state_d     = ST_WRITE;
                end else if (timeout_hit) begin
                    state_d = ST_ERROR;
                end
            end
            ST_WRITE: begin
                asm_valid      = rx_valid;
                words_loaded_d = words_loaded_q + 1'b1;
                state_d = (32'(words_loaded_q) + 32'd1 == 32'(n_q)) ? ST_DONE : ST_RECV;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q        <= ST_IDLE;
            n_q            <= '0;
            words_loaded_q <= '0;
            timeout_q      <= '0;
            mem_we_q       <= 1'b0;
            mem_addr_q     <= '0;
            mem_wdata_q    <= '0;
        end else begin
            state_q        <= state_d;
            n_q            <= n_d;
            words_loaded_q <= words_loaded_d;
            timeout_q      <= timeout_d;
            mem_we_q       <= mem_we_d;
            mem_addr_q     <= mem_addr_d;
            mem_wdata_q    <= mem_wdata_d;
        end
    end

    assign mem_we       = mem_we_q;
    assign mem_addr     = mem_addr_q;
    assign mem_wdata    = mem_wdata_q;
    assign cpu_hold     = (state_q != ST_IDLE) && (state_q != ST_DONE);
    assign done         = (state_q == ST_DONE);
    assign error        = (state_q == ST_ERROR);
    assign words_loaded = words_loaded_q;

endmodule

// File: tb/tb_prog_loader.sv
// Self-checking bench for prog_loader: fixed scenarios plus a table of randomized loads
// checked against a stream-parsing reference model.
module tb_prog_loader;

    localparam int AW = 4;
    localparam int IW = 32;
    localparam int TO = 50;

    logic          clock = 1'b0;
    logic          reset, start, rx_valid;
    logic [7:0]    rx_data;
    logic          mem_we, cpu_hold, done, error;
    logic [AW-1:0] mem_addr;
    logic [IW-1:0] mem_wdata;
    logic [AW:0]   words_loaded;

    prog_loader #(.ADDR_WIDTH(AW), .ISA_WIDTH(IW), .TIMEOUT_CYCLES(TO)) dut (
        .clock        (clock),
        .reset        (reset),
        .start        (start),
        .rx_data      (rx_data),
        .rx_valid     (rx_valid),
        .mem_we       (mem_we),
        .mem_addr     (mem_addr),
        .mem_wdata    (mem_wdata),
        .cpu_hold     (cpu_hold),
        .done         (done),
        .error        (error),
        .words_loaded (words_loaded)
    );

    always #5 clock = ~clock;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    always @(posedge clock) cyc <= cyc + 1;

    logic [AW+IW-1:0] wq[$];
    logic [7:0]       bq[$];

    always @(negedge clock) if (mem_we === 1'b1) wq.push_back({mem_addr, mem_wdata});

    typedef struct {
        int n;
        int gap_max;
        bit exp_done;
        bit exp_err;
        int exp_words;
    } vec_t;
    vec_t tbl[6];

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic send_byte(input logic [7:0] b, input int gap);
        rx_valid = 1'b1;
        rx_data  = b;
        @(posedge clock); #1;
        rx_valid = 1'b0;
        rx_data  = $urandom;
        repeat (gap) begin @(posedge clock); #1; end
    endtask

    task automatic pulse_start();
        start = 1'b1;
        @(posedge clock); #1;
        start = 1'b0;
    endtask

    task automatic send_bq(input int gap_max);
        foreach (bq[i]) send_byte(bq[i], (gap_max == 0) ? 0 : $urandom_range(gap_max, 0));
    endtask

    task automatic build_bq(input int n);
        bq.delete();
        bq.push_back(8'(n >> 8));
        bq.push_back(8'(n));
        if (n <= (1 << AW))
            for (int i = 0; i < 4 * n; i++) bq.push_back(8'($urandom));
    endtask

    task automatic wait_end(input string nm, input int maxc);
        int seen = 0;
        for (int i = 0; i < maxc && seen == 0; i++) begin
            @(negedge clock);
            if (done === 1'b1 || error === 1'b1) seen = 1;
        end
        if (seen == 0) chk({nm, "_end_wait"}, 0, 1);
    endtask

    // Reference: parse the byte stream (header count, then big-endian words) into expected writes.
    task automatic check_load(input string nm, input bit exp_done, input bit exp_err, input int exp_words);
        int nn;
        int nw;
        logic [AW+IW-1:0] e;
        nn = (int'(bq[0]) << 8) | int'(bq[1]);
        nw = (nn > (1 << AW)) ? 0 : nn;
        chk({nm, "_nwrites"}, wq.size(), nw);
        for (int i = 0; i < nw && i < wq.size(); i++) begin
            e = {AW'(i), bq[2+4*i], bq[3+4*i], bq[4+4*i], bq[5+4*i]};
            chk($sformatf("%s_write%0d", nm, i), wq[i], e);
        end
        chk({nm, "_done"}, done, exp_done);
        chk({nm, "_error"}, error, exp_err);
        chk({nm, "_cpu_hold"}, cpu_hold, exp_err);
        chk({nm, "_words"}, words_loaded, exp_words);
        chk({nm, "_we_idle"}, mem_we, 0);
    endtask

    initial begin
        #5000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int t0;
        int lat;
        reset = 1'b1; start = 1'b0; rx_valid = 1'b0; rx_data = '0;
        repeat (3) @(posedge clock);
        #1 reset = 1'b0;

        chk("rst_we", mem_we, 0);
        chk("rst_addr", mem_addr, 0);
        chk("rst_wdata", mem_wdata, 0);
        chk("rst_hold", cpu_hold, 0);
        chk("rst_done", done, 0);
        chk("rst_error", error, 0);
        chk("rst_words", words_loaded, 0);

        // Normal load with the documented image
        wq.delete();
        bq = '{8'h00, 8'h02, 8'h12, 8'h34, 8'h56, 8'h78, 8'h9A, 8'hBC, 8'hDE, 8'hF0};
        pulse_start();
        chk("start_hold", cpu_hold, 1);
        send_bq(1);
        wait_end("normal", 20);
        chk("normal_w0", wq.size() > 0 ? wq[0] : '0, {4'd0, 32'h12345678});
        chk("normal_w1", wq.size() > 1 ? wq[1] : '0, {4'd1, 32'h9ABCDEF0});
        check_load("normal", 1, 0, 2);

        // Bytes arriving in DONE are ignored
        send_byte(8'h55, 2);
        chk("done_ignore_we", wq.size(), 2);
        chk("done_ignore_state", done, 1);

        // Timeout: header promises one word, only two bytes follow
        wq.delete();
        bq = '{8'h00, 8'h01, 8'hAA, 8'hBB};
        pulse_start();
        chk("restart_done_clr", done, 0);
        send_bq(0);
        t0  = cyc;
        lat = -1;
        for (int i = 0; i < 200 && lat < 0; i++) begin
            @(negedge clock);
            if (error === 1'b1) lat = cyc - t0;
        end
        chk("timeout_latency", lat, TO);
        chk("timeout_nowrite", wq.size(), 0);
        chk("timeout_hold", cpu_hold, 1);

        // Reset mid-load, then reload
        wq.delete();
        @(posedge clock); #1;
        bq = '{8'h00, 8'h02, 8'hCA, 8'hFE, 8'hF0, 8'h0D};
        pulse_start();
        send_bq(0);
        repeat (2) begin @(posedge clock); #1; end
        chk("midrst_words_before", words_loaded, 1);
        reset = 1'b1;
        @(posedge clock); #1;
        reset = 1'b0;
        chk("midrst_hold", cpu_hold, 0);
        chk("midrst_words", words_loaded, 0);
        chk("midrst_done", done, 0);
        chk("midrst_error", error, 0);
        chk("midrst_partial", wq.size() > 0 ? wq[0] : '0, {4'd0, 32'hCAFEF00D});
        wq.delete();
        build_bq(2);
        pulse_start();
        send_bq(2);
        wait_end("reload", 20);
        check_load("reload", 1, 0, 2);

        // Randomized table of loads
        tbl = '{
            '{n: 2,  gap_max: 3, exp_done: 1, exp_err: 0, exp_words: 2},
            '{n: 0,  gap_max: 2, exp_done: 1, exp_err: 0, exp_words: 0},
            '{n: 17, gap_max: 2, exp_done: 0, exp_err: 1, exp_words: 0},
            '{n: 3,  gap_max: 0, exp_done: 1, exp_err: 0, exp_words: 3},
            '{n: 16, gap_max: 0, exp_done: 1, exp_err: 0, exp_words: 16},
            '{n: 1,  gap_max: 5, exp_done: 1, exp_err: 0, exp_words: 1}
        };
        for (int v = 0; v < 6; v++) begin
            wq.delete();
            build_bq(tbl[v].n);
            pulse_start();
            send_bq(tbl[v].gap_max);
            wait_end($sformatf("vec%0d", v), 20);
            check_load($sformatf("vec%0d", v), tbl[v].exp_done, tbl[v].exp_err, tbl[v].exp_words);
            @(posedge clock); #1;
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
